// File: rtl/mem_if_pkg.sv
// Shared types for the data-memory responder.
// State encoding, error causes and wait-counter width.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_BOTH  = 2'b01,
    ERR_ALIGN = 2'b10,
    ERR_RANGE = 2'b11
  } err_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/word_ram.sv
// Single-port word RAM: synchronous write, registered read.
// Contents are deliberately not reset.
module word_ram #(
  parameter int DEPTH_WORDS = 128,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request per arm, inserts
// wait states, then pulses mem_ready with data/error status.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 128,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WC = CNT_W'(WAIT_CYCLES);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_arm;
  logic             r_rd, r_wr;
  logic [31:0]      r_addr, r_wdata;
  logic             r_err, r_rd_ok;

  logic             w_idle, w_accept, w_go;
  logic             w_rd, w_wr;
  logic [31:0]      w_addr, w_wdata;
  logic [31:2]      w_off;
  err_t             w_cause;
  logic             w_ok, w_we, w_re;
  logic [31:0]      w_rdata;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && r_arm && (MemRead || MemWrite);

  // With zero wait states the commit edge is the accept edge,
  // so the live request is used before it lands in the capture regs.
  assign w_rd    = w_idle ? MemRead    : r_rd;
  assign w_wr    = w_idle ? MemWrite   : r_wr;
  assign w_addr  = w_idle ? dAddress   : r_addr;
  assign w_wdata = w_idle ? dWriteData : r_wdata;

  assign w_off = w_addr[31:2] - BASE_ADDR[31:2];

  always_comb begin
    w_cause = ERR_NONE;
    if (w_rd && w_wr)
      w_cause = ERR_BOTH;
    else if (w_addr[1:0] != 2'b00)
      w_cause = ERR_ALIGN;
    else if (w_addr[31:2] < BASE_ADDR[31:2] ||
             w_off[31:AW+2] != '0)
      w_cause = ERR_RANGE;
  end

  assign w_ok = (w_cause == ERR_NONE);
  assign w_go = (w_accept && WC == '0) ||
                (r_state == WAIT && r_cnt == CNT_W'(1));
  assign w_we = w_go && w_wr && w_ok;
  assign w_re = w_go && w_rd && w_ok;

  word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_off[AW+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = (WC == '0) ? RESP : WAIT;
      WAIT: if (r_cnt == CNT_W'(1)) w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_ready = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      IDLE: ;
      WAIT: busy = 1'b1;
      RESP: begin
        busy      = 1'b1;
        mem_ready = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_err   = r_err;
  assign dReadData = r_rd_ok ? w_rdata : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_arm   <= 1'b1;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      if (!MemRead && !MemWrite) r_arm <= 1'b1;
      else if (w_accept)         r_arm <= 1'b0;
      if (w_accept) begin
        r_cnt   <= WC;
        r_rd    <= MemRead;
        r_wr    <= MemWrite;
        r_addr  <= dAddress;
        r_wdata <= dWriteData;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      r_err   <= w_go && !w_ok;
      r_rd_ok <= w_re;
    end
  end

endmodule
